// File: rtl/l3_if_pkg.sv
// Shared types and sizing for the L3 line initiator.
// One line is eight 64-bit beats.
package l3_if_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BEAT_BYTES = 8;
    localparam int BEATS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } l3_init_state_e;

    typedef logic [511:0] line_t;

endpackage

// File: rtl/l3_line_initiator.sv
// Splits one L2 line request into sequential L3 beats
// and returns the assembled line upstream.
module l3_line_initiator #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_req_valid_i,
    output logic                    line_req_ready_o,
    input  logic [ADDR_W-1:0]       line_req_addr_i,
    input  logic                    line_req_write_i,
    input  logic [BEATS*DATA_W-1:0] line_req_wdata_i,
    output logic                    line_resp_valid_o,
    input  logic                    line_resp_ready_i,
    output logic [BEATS*DATA_W-1:0] line_resp_rdata_o,
    output logic                    line_resp_write_o,
    output logic                    req_valid_o,
    output logic [ADDR_W-1:0]       req_addr_o,
    output logic                    req_write_o,
    output logic [DATA_W-1:0]       req_wdata_o,
    output logic                    resp_ready_o,
    input  logic                    resp_valid_i,
    input  logic [DATA_W-1:0]       resp_rdata_i,
    output logic                    spurious_resp_o
);
    import l3_if_pkg::*;

    localparam int LINE_W = BEATS * DATA_W;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int BW     = $clog2(BEATS);

    l3_init_state_e state, state_nx;

    logic [BW-1:0]     beat;
    logic [LINE_W-1:0] line_q;
    logic [ADDR_W-1:0] base;
    logic              wr_q;
    logic              spur_q;
    logic              last;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;
    logic              unused_addr_lo;

    assign unused_addr_lo = ^line_req_addr_i[OFF_W-1:0];

    assign last      = (beat == BW'(BEATS-1));
    // base is line aligned, so the beat offset never carries
    assign beat_addr = base + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);
    assign beat_data = line_q[beat*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (line_req_valid_i) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (resp_valid_i) state_nx = last ? RESP : ISSUE;
            RESP:  if (line_resp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat   <= '0;
            line_q <= '0;
            base   <= '0;
            wr_q   <= 1'b0;
        end else begin
            if (state == IDLE && line_req_valid_i) begin
                base   <= {line_req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                wr_q   <= line_req_write_i;
                line_q <= line_req_write_i ? line_req_wdata_i : '0;
                beat   <= '0;
            end
            if (state == WAIT && resp_valid_i) begin
                if (!wr_q) begin
                    line_q[beat*DATA_W +: DATA_W] <= resp_rdata_i;
                end
                if (!last) begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_q <= 1'b0;
        end else if (resp_valid_i && state != WAIT) begin
            spur_q <= 1'b1;
        end
    end

    assign spurious_resp_o = spur_q;

    always_comb begin
        line_req_ready_o  = 1'b0;
        req_valid_o       = 1'b0;
        resp_ready_o      = 1'b0;
        req_addr_o        = '0;
        req_write_o       = 1'b0;
        req_wdata_o       = '0;
        line_resp_valid_o = 1'b0;
        line_resp_write_o = 1'b0;
        line_resp_rdata_o = '0;
        unique case (state)
            IDLE: line_req_ready_o = 1'b1;
            ISSUE: begin
                req_valid_o  = 1'b1;
                resp_ready_o = 1'b1;
                req_addr_o   = beat_addr;
                req_write_o  = wr_q;
                req_wdata_o  = beat_data;
            end
            WAIT: resp_ready_o = 1'b1;
            RESP: begin
                line_resp_valid_o = 1'b1;
                line_resp_write_o = wr_q;
                line_resp_rdata_o = wr_q ? '0 : line_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l3_line_initiator.sv
// Bench for l3_line_initiator against an L3 word memory
// model and a line-level reference model.
module tb_l3_line_initiator;
    import l3_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_req_valid_i = 1'b0;
    logic        line_req_ready_o;
    logic [63:0] line_req_addr_i = '0;
    logic        line_req_write_i = 1'b0;
    line_t       line_req_wdata_i = '0;
    logic        line_resp_valid_o;
    logic        line_resp_ready_i = 1'b0;
    line_t       line_resp_rdata_o;
    logic        line_resp_write_o;
    logic        req_valid_o;
    logic [63:0] req_addr_o;
    logic        req_write_o;
    logic [63:0] req_wdata_o;
    logic        resp_ready_o;
    logic        resp_valid_i;
    logic [63:0] resp_rdata_i;
    logic        spurious_resp_o;

    always #5 clk = ~clk;

    l3_line_initiator dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .line_req_valid_i  (line_req_valid_i),
        .line_req_ready_o  (line_req_ready_o),
        .line_req_addr_i   (line_req_addr_i),
        .line_req_write_i  (line_req_write_i),
        .line_req_wdata_i  (line_req_wdata_i),
        .line_resp_valid_o (line_resp_valid_o),
        .line_resp_ready_i (line_resp_ready_i),
        .line_resp_rdata_o (line_resp_rdata_o),
        .line_resp_write_o (line_resp_write_o),
        .req_valid_o       (req_valid_o),
        .req_addr_o        (req_addr_o),
        .req_write_o       (req_write_o),
        .req_wdata_o       (req_wdata_o),
        .resp_ready_o      (resp_ready_o),
        .resp_valid_i      (resp_valid_i),
        .resp_rdata_i      (resp_rdata_i),
        .spurious_resp_o   (spurious_resp_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // L3 word memory: accepts on req_valid && resp_ready,
    // answers after mem_delay extra cycles
    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
    } beat_t;

    bit [63:0]   l3_mem [longint unsigned];
    beat_t       issued [$];
    logic        mem_rv = 1'b0;
    logic [63:0] mem_rd = '0;
    logic        tb_rv = 1'b0;
    int          mem_delay = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pdata = '0;
    logic [63:0] rd_tmp;

    assign resp_valid_i = mem_rv | tb_rv;
    assign resp_rdata_i = mem_rd;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_rv <= 1'b0;
            pend   <= 1'b0;
            cnt    <= 0;
        end else begin
            mem_rv <= 1'b0;
            if (req_valid_o && resp_ready_o) begin
                issued.push_back('{req_write_o, req_addr_o, req_wdata_o});
                if (req_write_o) begin
                    l3_mem[req_addr_o] = req_wdata_o;
                    rd_tmp = '0;
                end else begin
                    rd_tmp = l3_mem.exists(req_addr_o) ? l3_mem[req_addr_o] : '0;
                end
                if (mem_delay == 0) begin
                    mem_rv <= 1'b1;
                    mem_rd <= rd_tmp;
                end else begin
                    pend  <= 1'b1;
                    cnt   <= mem_delay;
                    pdata <= rd_tmp;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    mem_rv <= 1'b1;
                    mem_rd <= pdata;
                    pend   <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // line-level reference: whole lines keyed by aligned address
    line_t ref_lines [longint unsigned];

    function automatic line_t ref_access(input logic [63:0] addr,
                                         input bit wr, input line_t wdata);
        logic [63:0] base;
        base = addr & ~64'h3f;
        if (wr) begin
            ref_lines[base] = wdata;
            return '0;
        end
        return ref_lines.exists(base) ? ref_lines[base] : '0;
    endfunction

    function automatic line_t ramp(input logic [63:0] first);
        line_t l;
        l = '0;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = first + 64'(i);
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_line_req_ready"}, line_req_ready_o, 1);
        chk({tag, "_line_resp_valid"}, line_resp_valid_o, 0);
        chk({tag, "_line_resp_rdata"}, line_resp_rdata_o, 0);
        chk({tag, "_line_resp_write"}, line_resp_write_o, 0);
        chk({tag, "_req_bus"},
            {req_valid_o, req_write_o, resp_ready_o, req_addr_o, req_wdata_o}, 0);
        chk({tag, "_spurious"}, spurious_resp_o, 0);
    endtask

    task automatic run_line(input logic [63:0] addr, input bit wr,
                            input line_t wdata, input int hold,
                            output line_t rdata, output logic rwr,
                            output int lat);
        issued.delete();
        @(negedge clk);
        chk("accept_ready", line_req_ready_o, 1);
        line_req_valid_i = 1'b1;
        line_req_addr_i  = addr;
        line_req_write_i = wr;
        line_req_wdata_i = wdata;
        @(posedge clk);
        @(negedge clk);
        line_req_valid_i = 1'b0;
        lat = 1;
        while (!line_resp_valid_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!line_resp_valid_o) begin
            errors++;
            $display("FAIL resp_timeout actual cycles %0d required <400", lat);
            rdata = '0;
            rwr = 1'b0;
            return;
        end
        rdata = line_resp_rdata_o;
        rwr   = line_resp_write_o;
        for (int h = 0; h < hold; h++) begin
            line_req_valid_i = 1'b1;
            line_req_addr_i  = 64'h9000;
            @(negedge clk);
            chk($sformatf("hold%0d", h),
                {line_resp_valid_o, line_req_ready_o, line_resp_write_o, line_resp_rdata_o},
                {1'b1, 1'b0, rwr, rdata});
        end
        line_req_valid_i  = 1'b0;
        line_resp_ready_i = 1'b1;
        @(negedge clk);
        line_resp_ready_i = 1'b0;
        chk("post_hs", {line_req_ready_o, line_resp_valid_o}, 2'b10);
    endtask

    task automatic check_line(input string name, input logic [63:0] addr,
                              input bit wr, input line_t wdata, input int hold,
                              input line_t exp_line, input logic [63:0] exp_base,
                              input bit check_lat);
        line_t rdata;
        logic  rwr;
        int    lat;
        run_line(addr, wr, wdata, hold, rdata, rwr, lat);
        chk({name, "_rdata"}, rdata, exp_line);
        chk({name, "_write"}, rwr, wr);
        chk({name, "_nbeats"}, issued.size(), 8);
        if (issued.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_beat%0d_addr", name, i), issued[i].a,
                    exp_base + 64'(8 * i));
                chk($sformatf("%s_beat%0d_w", name, i), issued[i].w, wr);
                if (wr) chk($sformatf("%s_beat%0d_wd", name, i), issued[i].d,
                            wdata[64*i +: 64]);
            end
        end
        if (check_lat) chk({name, "_latency"}, lat, 17);
    endtask

    typedef struct {
        logic [63:0] addr;
        bit          wr;
        logic [63:0] wfirst;
        logic [63:0] exp_base;
        logic [63:0] rfirst;
    } vec_t;

    vec_t   vecs [4];
    line_t  wd;
    line_t  exp_l;
    line_t  dummy_rd;
    logic   dummy_w;
    int     dummy_lat;
    int     guard;
    bit     saw_resp;
    logic [63:0] lines [4];

    initial begin
        vecs[0] = '{64'h1000, 1'b0, 64'h0,  64'h1000, 64'hA0};
        vecs[1] = '{64'h2040, 1'b1, 64'hB0, 64'h2040, 64'h0};
        vecs[2] = '{64'h2040, 1'b0, 64'h0,  64'h2040, 64'hB0};
        vecs[3] = '{64'h1027, 1'b0, 64'h0,  64'h1000, 64'hA0};

        for (int i = 0; i < 8; i++) l3_mem[64'h1000 + 64'(8*i)] = 64'hA0 + 64'(i);
        ref_lines[64'h1000] = ramp(64'hA0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        for (int v = 0; v < 4; v++) begin
            wd = vecs[v].wr ? ramp(vecs[v].wfirst) : rand_line();
            exp_l = (vecs[v].rfirst != 0) ? ramp(vecs[v].rfirst) : '0;
            check_line($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wr, wd, 0,
                       exp_l, vecs[v].exp_base, 1'b1);
            void'(ref_access(vecs[v].addr, vecs[v].wr, wd));
        end

        // response back-pressure with new requests presented
        check_line("stall", 64'h1000, 1'b0, '0, 5, ramp(64'hA0), 64'h1000, 1'b1);

        // reset in the middle of a fill
        issued.delete();
        @(negedge clk);
        line_req_valid_i = 1'b1;
        line_req_addr_i  = 64'h1000;
        line_req_write_i = 1'b0;
        @(negedge clk);
        line_req_valid_i = 1'b0;
        guard = 0;
        while (issued.size() < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_beats", issued.size(), 4);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw_resp = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (line_resp_valid_o) saw_resp = 1'b1;
        end
        chk("midrst_no_resp", saw_resp, 0);
        check_line("post_rst", 64'h1000, 1'b0, '0, 0, ramp(64'hA0), 64'h1000, 1'b1);

        // stray L3 response while idle
        @(negedge clk);
        tb_rv = 1'b1;
        @(negedge clk);
        tb_rv = 1'b0;
        chk("spur_set", spurious_resp_o, 1);
        repeat (4) @(negedge clk);
        chk("spur_sticky", spurious_resp_o, 1);
        check_line("post_spur", 64'h2040, 1'b0, '0, 0, ramp(64'hB0), 64'h2040, 1'b1);
        chk("spur_still", spurious_resp_o, 1);

        // randomized traffic against the line reference
        lines[0] = 64'h1000;
        lines[1] = 64'h2040;
        lines[2] = 64'h3000;
        lines[3] = 64'h7fc0;
        for (int n = 0; n < 24; n++) begin
            logic [63:0] la;
            logic [63:0] a;
            bit          w;
            int          hold;
            la = lines[$urandom_range(3)];
            a  = la | 64'($urandom_range(63));
            w  = 1'($urandom_range(1));
            wd = rand_line();
            mem_delay = $urandom_range(3);
            hold = $urandom_range(2);
            exp_l = ref_access(a, w, wd);
            check_line($sformatf("rnd%0d", n), a, w, wd, hold, exp_l, la,
                       mem_delay == 0);
        end
        mem_delay = 0;

        run_line(64'h3000, 1'b0, '0, 0, dummy_rd, dummy_w, dummy_lat);
        chk("final_rd", dummy_rd, ref_access(64'h3000, 1'b0, '0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l3_line_initiator.md
Name: l3_line_initiator

Overview:
- Initiator-side master for the shared L3 word-request port.
- Accepts one 64-byte line request (fill or writeback) from the L2 miss/evict path and splits it into 8 sequential 64-bit L3 beats.
- Collects the beat responses and returns the assembled line upstream.
- Exactly one L3 beat is in flight at a time; the block sits between the L2 controller and the L3 request port.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, L3 beat width in bits.
- BEATS, 8, beats per line; line width = BEATS*DATA_W = 512.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- line_req_valid_i  input  1  upstream line request valid.
- line_req_ready_o  output  1  block idle and can accept a line request.
- line_req_addr_i  input  ADDR_W  line address; bits [5:0] ignored (forced 0).
- line_req_write_i  input  1  1 = writeback, 0 = fill.
- line_req_wdata_i  input  512  writeback data; beat i = bits [64i+63:64i].
- line_resp_valid_o  output  1  assembled line response valid.
- line_resp_ready_i  input  1  upstream accepts response.
- line_resp_rdata_o  output  512  fill data; all zero for writebacks.
- line_resp_write_o  output  1  echo of request type.
- req_valid_o  output  1  L3 beat request valid.
- req_addr_o  output  ADDR_W  L3 beat byte address.
- req_write_o  output  1  L3 beat is a write.
- req_wdata_o  output  DATA_W  L3 beat write data.
- resp_ready_o  output  1  ready for L3 response; L3 only accepts a request when req_valid_o && resp_ready_o.
- resp_valid_i  input  1  L3 beat response valid (one-cycle pulse).
- resp_rdata_i  input  DATA_W  L3 beat read data (0 on writes).
- spurious_resp_o  output  1  sticky: resp_valid_i seen outside WAIT.

Behaviour:
- Reset values:
  - All outputs 0, except line_req_ready_o = 1.
  - State IDLE, beat counter 0, line buffer 0, base address 0.
  - Reset mid-operation aborts the line; no upstream response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - line_req_ready_o = 1.
  - On line_req_valid_i: latch base = {addr[ADDR_W-1:6], 6'b0} and the write flag.
  - Load the line buffer with wdata (write) or zeros (read); set beat = 0; go to ISSUE.
- ISSUE (one cycle):
  - req_valid_o = 1, resp_ready_o = 1, req_addr_o = base + beat*8, req_write_o = flag, req_wdata_o = buffer beat[beat].
  - Always go to WAIT next cycle; acceptance is guaranteed because resp_ready_o is driven by this block.
- WAIT:
  - req_valid_o = 0, resp_ready_o = 1.
  - On resp_valid_i, for a read: buffer beat[beat] <= resp_rdata_i. For a write, rdata is discarded.
  - If beat == BEATS-1, go to RESP; else beat++ and go to ISSUE.
  - With no resp_valid_i, stay in WAIT indefinitely (no timeout).
- RESP:
  - line_resp_valid_o = 1; rdata = buffer for reads, 0 for writes.
  - Outputs held stable until line_resp_ready_i, then go to IDLE.
  - line_req_ready_o goes high the cycle after the handshake (no same-cycle reuse).
- Latency with a single-cycle L3, measured from the accept cycle T:
  - Beats issue at T+1, T+3, …, T+15; responses arrive at T+2, …, T+16.
  - line_resp_valid_o = 1 at T+17.
- Addresses: beat offsets 0x00–0x38 never carry beyond bit 5, because base is line aligned.
- resp_valid_i in IDLE, ISSUE or RESP is ignored for data and sets spurious_resp_o (cleared only by reset).
- line_req_valid_i outside IDLE is ignored (ready = 0).

Decomposition:
- Package l3_if_pkg holds:
  - LINE_BYTES = 64, BEAT_BYTES = 8, BEATS = 8.
  - The state enum type l3_init_state_e.
  - typedef line_t = logic [511:0].
- No sub-module. FSM, counter and line buffer live in the single module.
- The bench pairs the block with the existing L3 memory model.

Test Plan:
- Preload L3 words 0x1000..0x1038 with 0xA0..0xA7; fill request addr 0x1000 → 8 reads at 0x1000 step 8; line_resp_valid_o at T+17; rdata beat i = 0xA0+i.
- Writeback addr 0x2040, wdata beat i = 0xB0+i → 8 writes with req_write_o = 1; line_resp_rdata_o = 0 and line_resp_write_o = 1. A subsequent fill of 0x2040 returns 0xB0..0xB7.
- Fill addr 0x1027 (misaligned) → beats issue at 0x1000..0x1038, same data as the first test.
- Hold line_resp_ready_i low for 5 cycles in RESP → valid and data stable; line_req_ready_o stays 0 and new requests are ignored; IDLE on the cycle after ready.
- Drive rst_n low after beat 3 of a fill → all outputs return to reset values; no line response; next fill completes normally.
- Pulse resp_valid_i while IDLE → spurious_resp_o = 1 and stays set; data path unaffected on the next fill.
